// File: rtl/axil_cfg_pkg.sv
// axil_cfg_pkg: shared state encoding and response constants for the AXI4-Lite config master
package axil_cfg_pkg;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA   = 32'hdead_beef;

endpackage

// File: rtl/axil_cfg_if.sv
// axil_cfg_if: AXI4-Lite bus bundle with master and slave views
interface axil_cfg_if;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_cfg_master.sv
// axil_cfg_master: one-at-a-time command stream to AXI4-Lite register access with response timeout
module axil_cfg_master
    import axil_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    axil_cfg_if.master  m_axi
);

    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          aw_done;
    logic          w_done;
    logic          waiting;
    logic          progress;
    logic          expired;

    assign aw_done  = !m_axi.awvalid || m_axi.awready;
    assign w_done   = !m_axi.wvalid || m_axi.wready;
    assign waiting  = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
    assign progress = state == WR_REQ  ? aw_done && w_done :
                      state == WR_RESP ? m_axi.bvalid :
                      state == RD_REQ  ? m_axi.arready :
                      state == RD_RESP ? m_axi.rvalid : 1'b0;
    // cnt holds the number of stalled cycles already spent, so this is the last one allowed
    assign expired  = waiting && !progress && (int'(cnt) + 1 == TIMEOUT_CYCLES);

    assign cmd_ready    = !rst && state == IDLE;
    assign m_axi.bready = !rst && state == WR_RESP;
    assign m_axi.rready = !rst && state == RD_RESP;
    assign m_axi.awprot = '0;
    assign m_axi.arprot = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= AXI_RESP_OKAY;
            rsp_timeout   <= 1'b0;
        end else begin
            cnt <= (!waiting || progress || expired) ? '0 : cnt + CW'(~&cnt);
            if (expired) begin
                state         <= RSP;
                m_axi.awvalid <= 1'b0;
                m_axi.wvalid  <= 1'b0;
                m_axi.arvalid <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_timeout   <= 1'b1;
                rsp_resp      <= AXI_RESP_SLVERR;
                rsp_rdata     <= TIMEOUT_RDATA;
            end else begin
                case (state)
                    IDLE: if (cmd_valid) begin
                        rsp_timeout <= 1'b0;
                        if (cmd_write) begin
                            state         <= WR_REQ;
                            m_axi.awaddr  <= cmd_addr;
                            m_axi.wdata   <= cmd_wdata;
                            m_axi.wstrb   <= cmd_wstrb;
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                        end else begin
                            state         <= RD_REQ;
                            m_axi.araddr  <= cmd_addr;
                            m_axi.arvalid <= 1'b1;
                        end
                    end
                    WR_REQ: begin
                        if (m_axi.awready) m_axi.awvalid <= 1'b0;
                        if (m_axi.wready) m_axi.wvalid <= 1'b0;
                        if (aw_done && w_done) state <= WR_RESP;
                    end
                    WR_RESP: if (m_axi.bvalid) begin
                        rsp_resp  <= m_axi.bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                    RD_REQ: if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        state         <= RD_RESP;
                    end
                    RD_RESP: if (m_axi.rvalid) begin
                        rsp_rdata <= m_axi.rdata;
                        rsp_resp  <= m_axi.rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                    RSP: if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb_axil_cfg_master: random command traffic against a delay-programmable AXI4-Lite slave and a register-map model
module tb_axil_cfg_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axil_cfg_if bus ();

    axil_cfg_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // slave: each channel waits a programmable number of cycles before responding
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_val = 2'b00, r_val = 2'b00;
    logic        sl_rst = 1'b1;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, pend_r = 1'b0;
    logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0, rd_q = '0;
    logic [3:0]  got_wstrb = '0;
    int          n_b = 0, awv_cyc = 0, wv_cyc = 0, arv_cyc = 0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mdl  [logic [31:0]];

    assign bus.awready = bus.awvalid && !aw_got && aw_cnt >= aw_dly;
    assign bus.wready  = bus.wvalid && !w_got && w_cnt >= w_dly;
    assign bus.bvalid  = aw_got && w_got && b_cnt >= b_dly;
    assign bus.bresp   = b_val;
    assign bus.arready = bus.arvalid && !pend_r && ar_cnt >= ar_dly;
    assign bus.rvalid  = pend_r && r_cnt >= r_dly;
    assign bus.rresp   = r_val;
    assign bus.rdata   = bus.rvalid ? rd_q : '0;

    always @(posedge clk) begin
        if (sl_rst) begin
            aw_got <= 1'b0; w_got <= 1'b0; pend_r <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
        end else begin
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            b_cnt  <= (aw_got && w_got && !(bus.bvalid && bus.bready)) ? b_cnt + 1 : 0;
            r_cnt  <= (pend_r && !(bus.rvalid && bus.rready)) ? r_cnt + 1 : 0;
            if (bus.awvalid && bus.awready) begin
                aw_got <= 1'b1;
                got_awaddr <= bus.awaddr;
            end
            if (bus.wvalid && bus.wready) begin
                w_got <= 1'b1;
                got_wdata <= bus.wdata;
                got_wstrb <= bus.wstrb;
            end
            if (bus.bvalid && bus.bready) begin
                smem[got_awaddr] = merge(smem.exists(got_awaddr) ? smem[got_awaddr] : 32'h0, got_wdata, got_wstrb);
                aw_got <= 1'b0;
                w_got <= 1'b0;
                n_b <= n_b + 1;
            end
            if (bus.arvalid && bus.arready) begin
                pend_r <= 1'b1;
                got_araddr <= bus.araddr;
                rd_q <= smem.exists(bus.araddr) ? smem[bus.araddr] : 32'hdead_beef;
            end
            if (bus.rvalid && bus.rready) pend_r <= 1'b0;
        end
    end

    always @(negedge clk) begin
        awv_cyc <= awv_cyc + int'(bus.awvalid);
        wv_cyc  <= wv_cyc + int'(bus.wvalid);
        arv_cyc <= arv_cyc + int'(bus.arvalid);
    end

    task automatic check_rst(input logic cr);
        check("rst_ctl", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready,
                              rsp_valid, rsp_timeout, rsp_resp}), 0);
        check("rst_awaddr", bus.awaddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_wstrb", 32'(bus.wstrb), 0);
        check("rst_araddr", bus.araddr, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(cr));
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // expected latency and response follow from the per-channel slave delays and the timeout budget
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int stall);
        bit          to;
        int          n, lat, mx, exp_lat;
        logic [31:0] ed;
        logic [1:0]  er;
        mx = aw_dly > w_dly ? aw_dly : w_dly;
        if (wr) begin
            to = mx >= TO || b_dly >= TO;
            exp_lat = mx >= TO ? TO + 1 : b_dly >= TO ? mx + TO + 2 : mx + b_dly + 3;
        end else begin
            to = ar_dly >= TO || r_dly >= TO;
            exp_lat = ar_dly >= TO ? TO + 1 : r_dly >= TO ? ar_dly + TO + 2 : ar_dly + r_dly + 3;
        end
        ed = to ? 32'hdead_beef : wr ? 32'h0 : (mdl.exists(a) ? mdl[a] : 32'hdead_beef);
        er = to ? 2'b10 : wr ? b_val : r_val;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_valid", 32'(rsp_valid), 1);
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, ed);
        check("rsp_resp", 32'(rsp_resp), 32'(er));
        check("rsp_timeout", 32'(rsp_timeout), 32'(to));
        check("axi_quiet", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 0);
        if (!to && wr) begin
            check("awaddr", got_awaddr, a);
            check("wdata", got_wdata, d);
            check("wstrb", 32'(got_wstrb), 32'(s));
        end
        if (!to && !wr) check("araddr", got_araddr, a);
        repeat (stall) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_rdata", rsp_rdata, ed);
            check("hold_resp", 32'(rsp_resp), 32'(er));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 0);
        check("cmd_ready_next", 32'(cmd_ready), 1);
        if (wr && !to) mdl[a] = merge(mdl.exists(a) ? mdl[a] : 32'h0, d, s);
        if (to) begin
            sl_rst = 1'b1;
            @(negedge clk);
            sl_rst = 1'b0;
        end
    endtask

    initial begin
        int awv0, wv0, arv0, b0, dl[5];
        @(negedge clk);
        check_rst(1'b0);
        rst = 1'b0;
        sl_rst = 1'b0;
        @(negedge clk);
        check_rst(1'b1);

        set_dly(0, 0, 0, 0, 0);
        txn(1'b1, 32'h500, 32'h1234_5678, 4'hF, 0);

        set_dly(0, 3, 0, 0, 0);
        awv0 = awv_cyc; wv0 = wv_cyc; b0 = n_b;
        txn(1'b1, 32'h508, 32'hcafe_f00d, 4'h5, 0);
        check("aw_cycles", awv_cyc - awv0, 1);
        check("w_cycles", wv_cyc - wv0, 4);
        check("b_count", n_b - b0, 1);

        set_dly(0, 0, 0, 0, 0);
        txn(1'b1, 32'h504, 32'h0000_0040, 4'hF, 0);
        set_dly(0, 0, 0, 5, 0);
        arv0 = arv_cyc;
        txn(1'b0, 32'h504, 32'h0, 4'h0, 0);
        check("ar_cycles", arv_cyc - arv0, 6);

        set_dly(0, 0, 0, 0, 0);
        txn(1'b0, 32'h50C, 32'h0, 4'h0, 0);

        set_dly(99, 99, 0, 0, 0);
        awv0 = awv_cyc;
        txn(1'b1, 32'h500, 32'h1111_1111, 4'hF, 0);
        check("to_aw_cycles", awv_cyc - awv0, TO);
        set_dly(7, 2, 7, 0, 0);
        txn(1'b1, 32'h500, 32'h2222_2222, 4'h3, 0);
        set_dly(0, 0, 0, 0, 8);
        txn(1'b0, 32'h500, 32'h0, 4'h0, 0);
        set_dly(0, 0, 0, 0, 7);
        r_val = 2'b01;
        txn(1'b0, 32'h500, 32'h0, 4'h0, 0);

        set_dly(0, 0, 0, 0, 0);
        b_val = 2'b11;
        txn(1'b1, 32'h508, 32'habcd_0123, 4'hC, 10);
        b_val = 2'b00;
        r_val = 2'b00;

        set_dly(99, 99, 0, 0, 0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h504; cmd_wdata = 32'h5555_aaaa; cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("mid_awvalid", 32'(bus.awvalid), 1);
        rst = 1'b1;
        sl_rst = 1'b1;
        @(negedge clk);
        check_rst(1'b0);
        rst = 1'b0;
        sl_rst = 1'b0;
        @(negedge clk);
        check_rst(1'b1);

        for (int k = 0; k < 150; k++) begin
            for (int j = 0; j < 5; j++)
                dl[j] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(6, 9)) : int'($urandom_range(0, 3));
            set_dly(dl[0], dl[1], dl[2], dl[3], dl[4]);
            b_val = 2'($urandom_range(0, 3));
            r_val = 2'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), 32'h500 + 32'($urandom_range(0, 7)) * 4,
                $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
